tt_um_serv: RTL and testbench
=============================

TT_UM_SERV -- requirements
Module: tt_um_serv

Interface
REQ-001 Parameters: none (width fixed at 8; prescaler select range 0..7).
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  design-select; when low, all registers hold.
REQ-005 ui_in  input  8  [0] count enable, [1] direction (0 up, 1 down), [2] index load, [3] sync clear, [6:4] prescaler select, [7] raw load.
REQ-006 uio_in  input  8  [3:0] load value; [7:4] ignored.
REQ-007 uo_out  output  8  Johnson counter state.
REQ-008 uio_out  output  8  [3:0] = 0, [4] wrap pulse, [5] illegal-state flag, [6] prescaler tick, [7] direction echo (ui_in[1]).
REQ-009 uio_oe  output  8  constant 8'hF0.

Function
REQ-010 Legal states: 16 Johnson patterns; index k 0..8 -> (2^k)-1; k 9..15 -> (8'hFF << (k-8)) truncated to 8 bits (e.g. 0->00, 1->01, 8->FF, 9->FE, 15->80).
REQ-011 Up step: state <= {state[6:0], ~state[7]} (index+1 mod 16); down step: state <= {~state[0], state[7:1]} (index-1 mod 16).
REQ-012 Prescaler: 7-bit free-running counter incrementing every ena cycle; tick = (cnt & mask) == mask, mask = 2^sel-1; sel 0 -> tick every cycle, sel 7 -> every 128 cycles.
REQ-013 Count step occurs on a cycle with ena=1, ui_in[0]=1 and tick=1.
REQ-014 Priority per cycle (ena=1): clear > raw load > index load > count step > hold.
REQ-015 Clear: state <= 8'h00, prescaler counter <= 0, wrap <= 0.
REQ-016 Index load: state <= pattern(uio_in[3:0]) per REQ-010, independent of tick and ui_in[0].
REQ-017 Raw load: state <= {uio_in[3:0], uio_in[3:0]} unmodified (test path for illegal states).
REQ-018 Wrap: registered; high exactly one cycle after a count step that lands on index 0 (up 80->00 or down 01->00); loads/clear never assert it.
REQ-019 uio_out[6] is the combinational tick; uio_out[7] follows ui_in[1] combinationally.
REQ-020 Direction change takes effect on the next step, no extra latency.
REQ-021 Legality: state legal iff at most one adjacent-bit transition among bits 0..7.

Reset
REQ-022 rst_n low asynchronously forces state = 8'h00, prescaler = 0, wrap = 0, illegal flag = 0; release is synchronous in effect, first step on first qualifying edge after release.
REQ-023 Reset mid-count aborts the step; no wrap pulse is generated.

Configuration
REQ-024 Macro JOHNSON_SELFCORRECT_EN defined: uio_out[5] = registered illegal flag, set the cycle after state is illegal, and on the next count step an illegal state is replaced by 8'h00 instead of shifting; clear/load still take priority.
REQ-025 Macro undefined: uio_out[5] tied 0; illegal states shift per REQ-011 unchanged.

Structure
REQ-026 Package tt_um_serv_pkg: WIDTH=8, IDX_W=4, PS_W=7, RESET_STATE=8'h00, function idx_to_pattern, function is_legal.
REQ-027 One sub-module johnson_core (state register, step/load/clear, legality, wrap); prescaler and IO mapping stay in top.

Verification
REQ-028 Reset, ena=1, ui_in=8'h01 (up, sel 0): uo_out sequence 00,01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00; wrap high one cycle after 80->00.
REQ-029 ui_in=8'h03 (down) from 00: 80,C0,E0,...,01,00; wrap after 01->00.
REQ-030 ui_in=8'h31 (sel 3): one step every 8 cycles; uio_out[6] high 1 of 8 cycles.
REQ-031 uio_in=4'hA, ui_in[2]=1 one cycle -> uo_out=FC; same cycle ui_in[3]=1 -> uo_out=00 (clear wins).
REQ-032 Raw load uio_in=4'h5 -> uo_out=55; with JOHNSON_SELFCORRECT_EN uio_out[5]=1 next cycle and next step gives 00; without, next up step gives AB and uio_out[5]=0.
REQ-033 ena=0 with ui_in=8'h01 for 10 cycles -> uo_out unchanged; rst_n pulse mid-count -> uo_out=00 immediately, no wrap.

Source files
------------

// File: rtl/tt_um_serv_pkg.sv
// Shared constants and helpers for the 8-bit Johnson counter.
//   WIDTH       : counter width
//   IDX_W       : width of a Johnson index (16 legal states)
//   PS_W        : prescaler counter width
//   RESET_STATE : state after reset / clear (index 0)
//   idx_to_pattern : index 0..15 -> legal Johnson pattern
//   is_legal       : at most one adjacent-bit transition across the word
package tt_um_serv_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned PS_W  = 7;

  localparam logic [WIDTH-1:0] RESET_STATE = 8'h00;

  // Indices 0..8 fill ones from the bottom, 9..15 drain them from the bottom.
  function automatic logic [WIDTH-1:0] idx_to_pattern(input logic [IDX_W-1:0] idx);
    logic [WIDTH:0] ones;
    if (idx <= IDX_W'(WIDTH)) begin
      ones = ((WIDTH+1)'(1) << idx) - (WIDTH+1)'(1);
      return ones[WIDTH-1:0];
    end else begin
      return {WIDTH{1'b1}} << (idx - IDX_W'(WIDTH));
    end
  endfunction

  function automatic logic is_legal(input logic [WIDTH-1:0] state);
    int unsigned edges;
    edges = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (state[i] != state[i+1]) edges++;
    end
    return edges <= 1;
  endfunction

endpackage

// File: rtl/tt_um_serv_johnson_core.sv
// Johnson counter core: state register, step/load/clear, wrap pulse and
// optional illegal-state detection with self-correction.
// Optional feature macro: JOHNSON_SELFCORRECT_EN.
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : global enable, all registers hold when low
//   clear_i       : synchronous clear (highest priority)
//   raw_load_i    : load {load_val_i, load_val_i} unmodified
//   idx_load_i    : load legal pattern selected by load_val_i
//   step_i        : count step qualified by prescaler tick
//   dir_i         : 0 up, 1 down
//   load_val_i    : 4-bit load value
//   state_o       : counter state
//   wrap_o        : one-cycle pulse after a step lands on index 0
//   illegal_o     : registered illegal-state flag (0 when feature disabled)
module johnson_core
  import tt_um_serv_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             raw_load_i,
  input  logic             idx_load_i,
  input  logic             step_i,
  input  logic             dir_i,
  input  logic [IDX_W-1:0] load_val_i,
  output logic [WIDTH-1:0] state_o,
  output logic             wrap_o,
  output logic             illegal_o
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] shifted;
  logic             wrap_q, wrap_d;

  always_comb begin
    if (dir_i) shifted = {~state_q[0], state_q[WIDTH-1:1]};
    else       shifted = {state_q[WIDTH-2:0], ~state_q[WIDTH-1]};
  end

`ifdef JOHNSON_SELFCORRECT_EN
  logic illegal_q, illegal_d;
  logic cur_illegal;

  assign cur_illegal = !is_legal(state_q);
  assign illegal_d   = clear_i ? 1'b0 : cur_illegal;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_q <= 1'b0;
    end else if (en_i) begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal_o = illegal_q;
`else
  logic cur_illegal;

  assign cur_illegal = 1'b0;
  assign illegal_o   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    if (clear_i) begin
      state_d = RESET_STATE;
    end else if (raw_load_i) begin
      state_d = {load_val_i, load_val_i};
    end else if (idx_load_i) begin
      state_d = idx_to_pattern(load_val_i);
    end else if (step_i) begin
      if (cur_illegal) begin
        // Recovery jump, not a counted wrap.
        state_d = RESET_STATE;
      end else begin
        state_d = shifted;
        wrap_d  = (shifted == RESET_STATE);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RESET_STATE;
      wrap_q  <= 1'b0;
    end else if (en_i) begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
    end
  end

  assign state_o = state_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/tt_um_serv.sv
// Top: 8-bit Johnson counter with prescaler and IO mapping.
// Optional feature macro: JOHNSON_SELFCORRECT_EN (illegal flag + self-correction).
//   clk      : system clock
//   rst_n    : async active-low reset
//   ena      : design select, all registers hold when low
//   ui_in    : [0] count en, [1] dir, [2] index load, [3] clear,
//              [6:4] prescaler select, [7] raw load
//   uio_in   : [3:0] load value
//   uo_out   : counter state
//   uio_out  : [4] wrap, [5] illegal, [6] tick, [7] direction echo
//   uio_oe   : constant 8'hF0
module tt_um_serv
  import tt_um_serv_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic            count_en, dir, idx_load, clear, raw_load;
  logic [2:0]      ps_sel;
  logic [PS_W-1:0] ps_cnt_q, ps_cnt_d, ps_mask;
  logic            tick;
  logic            wrap, illegal;
  logic [WIDTH-1:0] state;
  logic            unused_uio;

  assign count_en = ui_in[0];
  assign dir      = ui_in[1];
  assign idx_load = ui_in[2];
  assign clear    = ui_in[3];
  assign ps_sel   = ui_in[6:4];
  assign raw_load = ui_in[7];

  assign unused_uio = ^uio_in[7:4];

  // mask = 2^sel - 1 built as the complement of all-ones shifted by sel.
  assign ps_mask  = ~({PS_W{1'b1}} << ps_sel);
  assign tick     = (ps_cnt_q & ps_mask) == ps_mask;
  assign ps_cnt_d = clear ? '0 : ps_cnt_q + PS_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt_q <= '0;
    end else if (ena) begin
      ps_cnt_q <= ps_cnt_d;
    end
  end

  johnson_core u_core (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (ena),
    .clear_i    (clear),
    .raw_load_i (raw_load),
    .idx_load_i (idx_load),
    .step_i     (count_en & tick),
    .dir_i      (dir),
    .load_val_i (uio_in[3:0]),
    .state_o    (state),
    .wrap_o     (wrap),
    .illegal_o  (illegal)
  );

  assign uo_out  = state;
  assign uio_out = {dir, tick, illegal, wrap, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_serv.sv
module tb_tt_um_serv;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  tt_um_serv dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: Johnson table plus abstract counter state.
  logic [7:0] pat[16];
  logic [7:0] m_state;
  int         m_cnt;
  logic       m_wrap, m_ill;

  function automatic int idx_of(input logic [7:0] s);
    for (int k = 0; k < 16; k++) if (pat[k] == s) return k;
    return -1;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 8'h00;
    m_cnt   = 0;
    m_wrap  = 1'b0;
    m_ill   = 1'b0;
  endtask

  task automatic drive(input logic en, input logic [7:0] ui, input logic [7:0] uio);
    int   sel, mask, k;
    logic tick_now, tick_post, ill_now, correct;
    exp_t e;
    @(negedge clk);
    ena    = en;
    ui_in  = ui;
    uio_in = uio;
    sel      = int'(ui[6:4]);
    mask     = (1 << sel) - 1;
    tick_now = ((m_cnt & mask) == mask);
    if (en) begin
      ill_now = (idx_of(m_state) < 0);
      correct = 1'b0;
`ifdef JOHNSON_SELFCORRECT_EN
      correct = ill_now;
`endif
      if (ui[3]) begin
        model_reset();
      end else begin
        m_cnt  = (m_cnt + 1) % 128;
        m_wrap = 1'b0;
        if (ui[7]) begin
          m_state = {uio[3:0], uio[3:0]};
        end else if (ui[2]) begin
          m_state = pat[uio[3:0]];
        end else if (ui[0] && tick_now) begin
          if (correct) begin
            m_state = 8'h00;
          end else begin
            k = idx_of(m_state);
            if (k >= 0) begin
              k       = ui[1] ? (k + 15) % 16 : (k + 1) % 16;
              m_state = pat[k];
              m_wrap  = (k == 0);
            end else if (ui[1]) begin
              m_state = {~m_state[0], m_state[7:1]};
            end else begin
              m_state = {m_state[6:0], ~m_state[7]};
            end
          end
        end
`ifdef JOHNSON_SELFCORRECT_EN
        m_ill = ill_now;
`else
        m_ill = 1'b0;
`endif
      end
    end
    tick_post = ((m_cnt & mask) == mask);
    e.uo  = m_state;
    e.uio = {ui[1], tick_post, m_ill, m_wrap, 4'h0};
    sb_q.push_back(e);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic pulse_reset();
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check8("async_reset_state", uo_out, 8'h00);
    check8("async_reset_flags", {6'b0, uio_out[5:4]}, 8'h00);
    model_reset();
    @(negedge clk);
    ena   = 1'b0;
    rst_n = 1'b1;
  endtask

  // Monitor: compare every cycle for which the stimulus queued an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check8("uo_out", uo_out, e.uo);
        check8("uio_out", uio_out, e.uio);
        check8("uio_oe", uio_oe, 8'hF0);
      end
    end
  end

  initial begin
    logic [7:0] ui, uio;
    logic       en;
    for (int k = 0; k < 16; k++) begin
      for (int b = 0; b < 8; b++) begin
        pat[k][b] = (k <= 8) ? (b < k) : (b >= k - 8);
      end
    end
    model_reset();

    repeat (2) @(negedge clk);
    check8("reset_state", uo_out, 8'h00);
    check8("reset_flags", {6'b0, uio_out[5:4]}, 8'h00);
    check8("reset_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;

    repeat (17) drive(1'b1, 8'h01, 8'h00);      // full up cycle with wrap
    drive(1'b1, 8'h08, 8'h00);
    repeat (17) drive(1'b1, 8'h03, 8'h00);      // full down cycle with wrap
    drive(1'b1, 8'h08, 8'h00);
    repeat (24) drive(1'b1, 8'h31, 8'h00);      // prescaler sel 3
    drive(1'b1, 8'h04, 8'h0A);                  // index load -> FC
    drive(1'b1, 8'h0C, 8'h0A);                  // clear beats load
    drive(1'b1, 8'h80, 8'h05);                  // raw load 55
    drive(1'b1, 8'h01, 8'h00);
    drive(1'b1, 8'h01, 8'h00);
    repeat (3) drive(1'b1, 8'h01, 8'h00);
    repeat (10) drive(1'b0, 8'h01, 8'h00);      // ena low holds everything
    drive(1'b1, 8'h03, 8'h00);                  // direction change on next step
    repeat (5) drive(1'b1, 8'h01, 8'h00);
    pulse_reset();
    repeat (3) drive(1'b1, 8'h01, 8'h00);

    for (int i = 0; i < 600; i++) begin
      en  = ($urandom_range(7) != 0);
      ui  = 8'($urandom);
      uio = 8'($urandom);
      ui[3] = ($urandom_range(15) == 0);
      ui[7] = ($urandom_range(11) == 0);
      ui[2] = ($urandom_range(7) == 0);
      if ($urandom_range(3) != 0) ui[6:4] = 3'($urandom_range(2));
      if ($urandom_range(199) == 0) pulse_reset();
      drive(en, ui, uio);
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
